// File: rtl/spsram_fifo_ctrl_if.sv
// Handshake and SRAM-pin bundle for spsram_fifo_ctrl.
// The slave modport is the controller; the master modport is the producer/consumer/SRAM side.
interface spsram_fifo_ctrl_if #(
  parameter int unsigned BW_DATA = 64,
  parameter int unsigned BW_ADDR = 6
);
  logic [BW_DATA-1:0] i_wr_data;
  logic               i_wr_valid;
  logic               o_wr_ready;
  logic [BW_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               i_rd_ready;
  logic               o_full;
  logic               o_empty;
  logic [BW_ADDR:0]   o_count;
  logic [BW_DATA-1:0] o_mem_data;
  logic [BW_ADDR-1:0] o_mem_addr;
  logic               o_mem_wen;
  logic               o_mem_cen;
  logic               o_mem_oen;
  logic [BW_DATA-1:0] i_mem_data;

  modport slave (
    input  i_wr_data, i_wr_valid, i_rd_ready, i_mem_data,
    output o_wr_ready, o_rd_data, o_rd_valid, o_full, o_empty, o_count,
    output o_mem_data, o_mem_addr, o_mem_wen, o_mem_cen, o_mem_oen
  );

  modport master (
    output i_wr_data, i_wr_valid, i_rd_ready, i_mem_data,
    input  o_wr_ready, o_rd_data, o_rd_valid, o_full, o_empty, o_count,
    input  o_mem_data, o_mem_addr, o_mem_wen, o_mem_cen, o_mem_oen
  );
endinterface

// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller over an external single-port SRAM with a one-entry registered output stage.
// Reads take priority on the SRAM port; read data lands one cycle after issue.
module spsram_fifo_ctrl #(
  parameter int unsigned BW_DATA = 64,
  parameter int unsigned BW_ADDR = 6
) (
  input logic                i_clk,
  input logic                i_rst,
  spsram_fifo_ctrl_if.slave  bus
);

  localparam logic [BW_ADDR:0]   DEPTH   = {1'b1, {BW_ADDR{1'b0}}};
  localparam logic [BW_ADDR:0]   CNT_ONE = {{BW_ADDR{1'b0}}, 1'b1};
  localparam logic [BW_ADDR-1:0] PTR_ONE = CNT_ONE[BW_ADDR-1:0];

  logic [BW_ADDR-1:0] r_wr_ptr;
  logic [BW_ADDR-1:0] r_rd_ptr;
  logic [BW_ADDR:0]   r_mem_cnt;
  logic               r_rd_pend;
  logic               r_rd_valid;
  logic [BW_DATA-1:0] r_rd_data;

  logic w_rd_go;
  logic w_wr_ready;
  logic w_wr_go;

  // Issue a read only when the output register will be free by the time the data lands.
  always_comb begin
    w_rd_go    = (r_mem_cnt != '0) && !r_rd_pend && (!r_rd_valid || bus.i_rd_ready);
    w_wr_ready = !i_rst && (r_mem_cnt != DEPTH) && !w_rd_go;
    w_wr_go    = bus.i_wr_valid && w_wr_ready;
  end

  always_comb begin
    bus.o_wr_ready = w_wr_ready;
    bus.o_rd_data  = r_rd_data;
    bus.o_rd_valid = r_rd_valid;
    bus.o_full     = (r_mem_cnt == DEPTH);
    bus.o_empty    = (r_mem_cnt == '0) && !r_rd_pend && !r_rd_valid;
    bus.o_count    = r_mem_cnt;
    bus.o_mem_cen  = w_rd_go || w_wr_go;
    bus.o_mem_wen  = w_wr_go;
    bus.o_mem_oen  = w_rd_go;
    bus.o_mem_addr = w_rd_go ? r_rd_ptr : r_wr_ptr;
    bus.o_mem_data = bus.i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_wr_go) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_go) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      // wr_go and rd_go are mutually exclusive, so the count moves by at most one.
      if (w_wr_go) begin
        r_mem_cnt <= r_mem_cnt + CNT_ONE;
      end else if (w_rd_go) begin
        r_mem_cnt <= r_mem_cnt - CNT_ONE;
      end

      r_rd_pend <= w_rd_go;

      if (r_rd_pend) begin
        r_rd_data  <= bus.i_mem_data;
        r_rd_valid <= 1'b1;
      end else if (r_rd_valid && bus.i_rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// Self-checking bench: queue-based FIFO model compared against the controller every cycle,
// with a behavioural single-port SRAM attached to the memory pins.
module tb_spsram_fifo_ctrl;

  localparam int unsigned BW_DATA = 64;
  localparam int unsigned BW_ADDR = 6;
  localparam int          DEPTH   = 64;
  localparam logic [63:0] PAT     = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spsram_fifo_ctrl_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) bus ();

  spsram_fifo_ctrl #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Behavioural SRAM: registered read output, write on cen & wen.
  logic [63:0] sram [DEPTH];
  always @(posedge clk) begin
    if (bus.o_mem_cen) begin
      if (bus.o_mem_wen) sram[bus.o_mem_addr] <= bus.o_mem_data;
      else if (bus.o_mem_oen) bus.i_mem_data <= sram[bus.o_mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words resident in SRAM kept as a queue, plus the in-flight and output slots.
  logic [63:0] data_q [$];
  logic [63:0] sent_q [$];
  logic [63:0] got_q  [$];
  int          m_count, m_wr_n, m_rd_n;
  bit          m_pend, m_valid;
  logic [63:0] m_pend_data, m_rd_data;
  bit          e_rd_go, e_wr_ready, e_wr_go;

  always @(negedge clk) begin
    if (rst) begin
      m_count = 0; m_wr_n = 0; m_rd_n = 0;
      m_pend = 0; m_valid = 0; m_pend_data = '0; m_rd_data = '0;
      data_q.delete();
      chk("rst_wr_ready", bus.o_wr_ready, 0);
      chk("rst_cen", bus.o_mem_cen, 0);
      chk("rst_rd_valid", bus.o_rd_valid, 0);
      chk("rst_rd_data", bus.o_rd_data, 0);
      chk("rst_empty", bus.o_empty, 1);
      chk("rst_full", bus.o_full, 0);
      chk("rst_count", bus.o_count, 0);
    end else begin
      e_rd_go    = (m_count != 0) && !m_pend && (!m_valid || bus.i_rd_ready);
      e_wr_ready = (m_count != DEPTH) && !e_rd_go;
      e_wr_go    = bus.i_wr_valid && e_wr_ready;

      chk("wr_ready", bus.o_wr_ready, e_wr_ready);
      chk("mem_cen", bus.o_mem_cen, e_rd_go || e_wr_go);
      chk("mem_wen", bus.o_mem_wen, e_wr_go);
      chk("mem_oen", bus.o_mem_oen, e_rd_go);
      chk("wen_and_oen", bus.o_mem_wen & bus.o_mem_oen, 0);
      chk("mem_addr", bus.o_mem_addr, e_rd_go ? 64'(m_rd_n % DEPTH) : 64'(m_wr_n % DEPTH));
      if (!e_rd_go) chk("mem_data", bus.o_mem_data, bus.i_wr_data);
      chk("rd_valid", bus.o_rd_valid, m_valid);
      if (m_valid) chk("rd_data", bus.o_rd_data, m_rd_data);
      chk("full", bus.o_full, m_count == DEPTH);
      chk("empty", bus.o_empty, (m_count == 0) && !m_pend && !m_valid);
      chk("count", bus.o_count, 64'(m_count));

      if (m_valid && bus.i_rd_ready) got_q.push_back(m_rd_data);

      if (m_pend) begin
        m_valid   = 1;
        m_rd_data = m_pend_data;
      end else if (m_valid && bus.i_rd_ready) begin
        m_valid = 0;
      end
      m_pend = e_rd_go;
      if (e_rd_go) begin
        m_pend_data = data_q.pop_front();
        m_count--;
        m_rd_n++;
      end
      if (e_wr_go) begin
        data_q.push_back(bus.i_wr_data);
        m_count++;
        m_wr_n++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    bit done = 0;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = v;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.o_wr_ready) done = 1;
      step();
    end
    n_checks++;
    if (done) sent_q.push_back(v);
    else begin
      n_errors++;
      $display("FAIL push_timeout actual=not_accepted expected=accepted data=%0h", v);
    end
  endtask

  task automatic drain();
    bit done = 0;
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bus.o_empty) done = 1;
      step();
    end
    chk("drain_reached_empty", done, 1);
  endtask

  task automatic compare_sb(input string name);
    chk({name, "_size"}, 64'(got_q.size()), 64'(sent_q.size()));
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++)
      chk({name, "_word"}, got_q[i], sent_q[i]);
  endtask

  task automatic clear_sb();
    sent_q.delete();
    got_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    bus.i_wr_data  = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", bus.o_wr_ready, 1);
    step();

    // Fill: output register captures word 0, SRAM then fills to capacity.
    clear_sb();
    for (int i = 0; i < 64; i++) push(64'(i));
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    chk("fill_count63", bus.o_count, 63);
    chk("fill_rd_data0", bus.o_rd_data, 0);
    chk("fill_rd_valid", bus.o_rd_valid, 1);
    chk("fill_not_full", bus.o_full, 0);
    step();
    push(64'd64);
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    chk("full_flag", bus.o_full, 1);
    chk("full_count", bus.o_count, 64);
    chk("full_wr_ready", bus.o_wr_ready, 0);
    step();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 64'd65;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_wr_ready", bus.o_wr_ready, 0);
      step();
    end
    bus.i_rd_ready = 1'b1;
    push(64'd65);
    drain();
    chk("drain_size_lit", 64'(got_q.size()), 66);
    if (got_q.size() == 66) begin
      chk("drain_first_lit", got_q[0], 0);
      chk("drain_last_lit", got_q[65], 65);
    end
    compare_sb("fill_drain");
    @(negedge clk);
    chk("drain_empty", bus.o_empty, 1);
    step();

    // Wrap-around rounds.
    for (int r = 0; r < 3; r++) begin
      clear_sb();
      bus.i_rd_ready = 1'b0;
      for (int i = 0; i < 50; i++) push(64'(r * 50 + i) ^ PAT);
      drain();
      if (got_q.size() > 0) chk("wrap_first_lit", got_q[0], 64'(r * 50) ^ PAT);
      compare_sb("wrap");
    end

    // Concurrent stream.
    clear_sb();
    bus.i_rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'(1000 + i));
    bus.i_rd_ready = 1'b1;
    for (int i = 4; i < 200; i++) push(64'(1000 + i));
    drain();
    compare_sb("stream");

    // Randomized traffic with varying bias.
    clear_sb();
    for (int i = 0; i < 1500; i++) begin
      bus.i_wr_valid = ($urandom_range(0, 3) < ((i / 300) % 4));
      bus.i_rd_ready = ($urandom_range(0, 3) != 0) ^ ((i / 500) == 1);
      bus.i_wr_data  = {$urandom, $urandom};
      @(negedge clk);
      if (bus.i_wr_valid && bus.o_wr_ready) sent_q.push_back(bus.i_wr_data);
      step();
    end
    drain();
    compare_sb("random");

    // Reset while a read is in flight.
    clear_sb();
    bus.i_rd_ready = 1'b0;
    push(64'h55);
    bus.i_wr_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_mem_oen) seen = 1;
      else step();
    end
    chk("inflight_rd_issued", seen, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_valid", bus.o_rd_valid, 0);
    chk("async_rst_empty", bus.o_empty, 1);
    chk("async_rst_wr_ready", bus.o_wr_ready, 0);
    chk("async_rst_cen", bus.o_mem_cen, 0);
    chk("async_rst_count", bus.o_count, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_inflight_rd_valid", bus.o_rd_valid, 0);
    step();
    clear_sb();
    push(64'h1234);
    drain();
    chk("inflight_size_lit", 64'(got_q.size()), 1);
    if (got_q.size() > 0) chk("inflight_next_lit", got_q[0], 64'h1234);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
